rep4_tx: RTL and testbench
==========================

Name: rep4_tx

Overview:
Serial transmitter for a 4-fold repetition-coded line, the sending end of the 4-input majority decoder used on the receive side.
- Accepts one parallel word through a valid/ready handshake.
- Frames the word as start, data LSB-first, then stop.
- Sends every frame bit as REP identical consecutive chips, so the far end recovers each bit by majority vote over one chip group.
- Sits between board-level data sources (switch banks, test counters) and the single-wire link to the decoder.

Parameters:
- DATA_W, 8, payload bits per frame.
- REP, 4, chips per frame bit (repetition factor), >=1.
- CLKS_PER_CHIP, 1, clk cycles each chip is held on tx_line, >=1.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  reset, synchronous, active-high.
- data_in  input  DATA_W  payload word, sampled on handshake.
- data_valid  input  1  source has a word.
- data_ready  output  1  block can accept a word.
- tx_line  output  1  coded serial line; idle high.
- tx_busy  output  1  frame in progress.
- group_strobe  output  1  one-cycle pulse on the first clk of each chip group (bench/receiver alignment aid).

Behaviour:
- Reset values, applied on the clk edge with rst=1: tx_line=1, data_ready=0, tx_busy=0, group_strobe=0, state=IDLE, all counters 0.
- First cycle after rst deasserts: data_ready=1.
- rst asserted mid-frame: frame abandoned on that edge, no partial stop sent, shift register cleared.
- Handshake: a transfer occurs on a clk edge with data_valid=1 and data_ready=1. data_in is latched into a shift register.
- data_ready=1 only in IDLE. data_valid during a frame is ignored and never queued.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on transfer.
  - START -> DATA after REP chips.
  - DATA -> STOP after DATA_W groups.
  - STOP -> IDLE after REP chips.
- Line levels: IDLE drives 1. START drives REP chips of 0. DATA drives shreg[0] for REP chips, then shifts right. STOP drives REP chips of 1.
- Timing: tx_line goes low on the edge after the transfer edge (latency 1 clk).
- Frame length: (DATA_W+2)*REP*CLKS_PER_CHIP clks with tx_busy=1. tx_busy is high from the first START clk through the last STOP clk.
- Back-to-back frames: after STOP the block spends at least 1 clk in IDLE (data_ready=1) before the next START. Minimum frame period is frame length + 1.
- Counters:
  - div_cnt counts 0..CLKS_PER_CHIP-1.
  - chip_cnt counts 0..REP-1 and advances when div_cnt wraps.
  - bit_cnt counts 0..DATA_W-1 and advances when chip_cnt wraps in DATA.
  - Widths are $clog2(max+1), minimum 1 bit. No counter exceeds its terminal value.
- group_strobe=1 on the clk where chip_cnt=0 and div_cnt=0 in START, DATA or STOP; otherwise 0.
- CLKS_PER_CHIP=1 and REP=1 are legal: plain UART-like NRZ at clk rate.

Optional Feature:
- Macro: REP4_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It sends the even-parity bit (XOR of the latched word) as REP chips. Frame length becomes (DATA_W+3)*REP*CLKS_PER_CHIP.
- Undefined: no PARITY state, no parity logic; frame as above.

Decomposition:
- Package rep4_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - default constants REP_DEF=4 and DATA_W_DEF=8;
  - line levels LINE_IDLE=1, LINE_START=0, LINE_STOP=1.
- One sub-module, rep4_chip_timer: contains div_cnt and chip_cnt. It outputs chip_tick (last clk of a chip), group_done (last clk of a group) and group_start. The top level keeps the FSM, bit_cnt and the shift register.

Test Plan:
- Defaults, send 0xA5: tx_line = 0000, then 1111 0000 1111 0000 0000 1111 0000 1111, then 1111. tx_busy high exactly 40 clks. data_ready returns to 1 on the clk after the last stop chip.
- Hold data_valid=1 with 0x3C during the whole 0xA5 frame: 0x3C is not taken mid-frame. It is accepted in the first IDLE clk, and its START begins exactly 1 clk after the 0xA5 STOP ends.
- CLKS_PER_CHIP=3, send 0x01: start low for 12 clks, then bit0 high for 12 clks, bits 1..7 low for 84 clks, stop high for 12 clks. group_strobe pulses 10 times, spaced 12 clks apart.
- Assert rst for 1 clk at clk 17 of a frame: next clk tx_line=1, tx_busy=0, data_ready=0. data_ready=1 the clk after rst deasserts. A fresh 0xFF then sends a complete, correct 40-clk frame.
- Loopback through a majority-of-4 decoder sampled at each group end, random 1000 words: decoded word equals the sent word. Repeat with one chip per group inverted: still equal.
- With REP4_TX_PARITY_EN, send 0xA5 then 0x07: parity groups 0000 and 1111 respectively; each frame is 44 clks.

Source files
------------

// File: rtl/rep4_pkg.sv
// Shared types and constants for the repetition-coded serial transmitter.
package rep4_pkg;

  // Frame sequencer states; PARITY is only reachable in parity-enabled builds
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int REP_DEF    = 4;
  localparam int DATA_W_DEF = 8;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  // Bits needed for a counter that runs 0..max_val, never less than one bit
  function automatic int cnt_w(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/rep4_chip_timer.sv
// Chip timing for the repetition-coded transmitter: div_cnt paces one chip,
// chip_cnt counts the chips of one group. Both counters sit at zero while
// disabled, so every frame starts on a clean group boundary.
module rep4_chip_timer
  import rep4_pkg::*;
#(
  parameter int REP           = REP_DEF,
  parameter int CLKS_PER_CHIP = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic chip_tick,
  output logic group_done,
  output logic group_start
);

  localparam int DIV_W  = cnt_w(CLKS_PER_CHIP - 1);
  localparam int CHIP_W = cnt_w(REP - 1);

  logic [DIV_W-1:0]  div_cnt_r;
  logic [CHIP_W-1:0] chip_cnt_r;
  logic              div_last_s;
  logic              chip_last_s;

  assign div_last_s  = (div_cnt_r == DIV_W'(CLKS_PER_CHIP - 1));
  assign chip_last_s = (chip_cnt_r == CHIP_W'(REP - 1));

  // chip_tick marks the last clk of a chip, group_done the last clk of a group
  assign chip_tick   = en && div_last_s;
  assign group_done  = chip_tick && chip_last_s;
  // counters will read zero on the next clk: either idle-cleared or wrapping
  assign group_start = !en || group_done;

  // Advance the chip divider and the chip-in-group counter
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r  <= '0;
      chip_cnt_r <= '0;
    end else if (!en) begin
      div_cnt_r  <= '0;
      chip_cnt_r <= '0;
    end else if (div_last_s) begin
      div_cnt_r  <= '0;
      chip_cnt_r <= chip_last_s ? '0 : chip_cnt_r + CHIP_W'(1);
    end else begin
      div_cnt_r  <= div_cnt_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/rep4_tx.sv
// Repetition-coded serial transmitter: start, DATA_W bits LSB-first, stop,
// each bit sent as REP identical chips of CLKS_PER_CHIP clks.
// Build option REP4_TX_PARITY_EN inserts an even-parity group before stop.
// All outputs are registered; each is loaded with the value belonging to the
// state/chip that starts on the following clk.
module rep4_tx
  import rep4_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int REP           = REP_DEF,
  parameter int CLKS_PER_CHIP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx_line,
  output logic              tx_busy,
  output logic              group_strobe
);

  localparam int BIT_W = cnt_w(DATA_W - 1);

  state_t            state_r;
  state_t            state_n_s;
  logic [DATA_W-1:0] shreg_r;
  logic [DATA_W-1:0] shift_s;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic              tx_line_r;
  logic              data_ready_r;
  logic              tx_busy_r;
  logic              group_strobe_r;
  logic              level_n_s;
  logic              xfer_s;
  logic              last_bit_s;
  logic              timer_en_s;
  logic              chip_tick_s;
  logic              group_done_s;
  logic              group_start_s;

`ifdef REP4_TX_PARITY_EN
  logic              parity_r;

  // Even parity over the accepted word
  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction
`endif

  assign xfer_s     = data_valid && data_ready_r;
  assign last_bit_s = (bit_cnt_r == BIT_W'(DATA_W - 1));
  assign shift_s    = shreg_r >> 1'b1;
  assign timer_en_s = (state_r != IDLE);

  assign data_ready   = data_ready_r;
  assign tx_line      = tx_line_r;
  assign tx_busy      = tx_busy_r;
  assign group_strobe = group_strobe_r;

  rep4_chip_timer #(
    .REP           (REP),
    .CLKS_PER_CHIP (CLKS_PER_CHIP)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .en          (timer_en_s),
    .chip_tick   (chip_tick_s),
    .group_done  (group_done_s),
    .group_start (group_start_s)
  );

  // Next state and the line level of the chip that follows this clk
  always_comb begin
    state_n_s = state_r;
    level_n_s = LINE_IDLE;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          state_n_s = START;
          level_n_s = LINE_START;
        end else begin
          state_n_s = IDLE;
          level_n_s = LINE_IDLE;
        end
      end
      START: begin
        if (group_done_s) begin
          state_n_s = DATA;
          level_n_s = shreg_r[0];
        end else begin
          level_n_s = LINE_START;
        end
      end
      DATA: begin
        if (group_done_s) begin
          if (last_bit_s) begin
`ifdef REP4_TX_PARITY_EN
            state_n_s = PARITY;
            level_n_s = parity_r;
`else
            state_n_s = STOP;
            level_n_s = LINE_STOP;
`endif
          end else begin
            level_n_s = shift_s[0];
          end
        end else begin
          level_n_s = shreg_r[0];
        end
      end
`ifdef REP4_TX_PARITY_EN
      PARITY: begin
        if (group_done_s) begin
          state_n_s = STOP;
          level_n_s = LINE_STOP;
        end else begin
          level_n_s = parity_r;
        end
      end
`endif
      STOP: begin
        if (group_done_s) begin
          state_n_s = IDLE;
          level_n_s = LINE_IDLE;
        end else begin
          level_n_s = LINE_STOP;
        end
      end
      default: begin
        state_n_s = IDLE;
        level_n_s = LINE_IDLE;
      end
    endcase
  end

  // Sequencer state, payload shifter, bit counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      shreg_r        <= '0;
      bit_cnt_r      <= '0;
      tx_line_r      <= LINE_IDLE;
      data_ready_r   <= 1'b0;
      tx_busy_r      <= 1'b0;
      group_strobe_r <= 1'b0;
`ifdef REP4_TX_PARITY_EN
      parity_r       <= 1'b0;
`endif
    end else begin
      state_r        <= state_n_s;
      data_ready_r   <= (state_n_s == IDLE);
      tx_busy_r      <= (state_n_s != IDLE);
      group_strobe_r <= group_start_s && (state_n_s != IDLE);
      // line only changes on a chip boundary or when a frame is launched
      if (xfer_s || chip_tick_s) begin
        tx_line_r <= level_n_s;
      end
      if (xfer_s) begin
        shreg_r   <= data_in;
        bit_cnt_r <= '0;
`ifdef REP4_TX_PARITY_EN
        parity_r  <= even_parity(data_in);
`endif
      end else if ((state_r == DATA) && group_done_s) begin
        shreg_r   <= shift_s;
        bit_cnt_r <= last_bit_s ? '0 : bit_cnt_r + BIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rep4_tx.sv
// Self-checking bench for rep4_tx: scoreboard of expected chips per clk plus
// a majority-of-REP loopback decoder on the default-parameter instance.
module tb_rep4_tx;

  localparam int DW  = 8;
  localparam int REP = 4;
`ifdef REP4_TX_PARITY_EN
  localparam int NG = DW + 3;
`else
  localparam int NG = DW + 2;
`endif
  localparam int FL = NG * REP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_a, line_a, busy_a, strobe_a;
  logic       ready_b, line_b, busy_b, strobe_b;

  always #5 clk = ~clk;

  rep4_tx #(.DATA_W(DW), .REP(REP), .CLKS_PER_CHIP(1)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_a), .data_valid(valid_a),
    .data_ready(ready_a), .tx_line(line_a), .tx_busy(busy_a), .group_strobe(strobe_a)
  );

  rep4_tx #(.DATA_W(DW), .REP(REP), .CLKS_PER_CHIP(3)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_b), .data_valid(valid_b),
    .data_ready(ready_b), .tx_line(line_b), .tx_busy(busy_b), .group_strobe(strobe_b)
  );

  int         checks = 0;
  int         failures = 0;
  logic       qa[$];
  logic       qb[$];
  logic [7:0] word_q[$];
  logic       inj_en = 1'b0;
  int         dec_frames = 0;

  // expected chip stream of one frame, one entry per clk of tx_busy
  function automatic void push_frame(input logic [7:0] w, input bit to_b);
    int   cpc;
    logic lvl;
    cpc = to_b ? 3 : 1;
    for (int g = 0; g < NG; g++) begin
      if (g == 0) lvl = 1'b0;
      else if (g <= DW) lvl = w[g-1];
      else if (g == NG - 1) lvl = 1'b1;
      else lvl = ^w;
      for (int k = 0; k < REP * cpc; k++) begin
        if (to_b) qb.push_back(lvl);
        else qa.push_back(lvl);
      end
    end
  endfunction

  // scoreboard and majority decoder for dut_a
  int         chip_i = 0, bit_i = 0, ones = 0, flip_pos = 0;
  logic [NG-1:0] fbits, ebits;
  logic       exp_l, dec_l;
  logic [7:0] dw;
  always @(negedge clk) begin
    if (busy_a === 1'b1) begin
      checks++;
      if (qa.size() == 0) begin
        failures++; $display("FAIL line_a_extra: got chip %b required no chip", line_a);
      end else begin
        exp_l = qa.pop_front();
        if (line_a !== exp_l) begin failures++; $display("FAIL line_a: got %b required %b", line_a, exp_l); end
      end
      dec_l = line_a ^ (inj_en && (chip_i == flip_pos));
      if (dec_l === 1'b1) ones++;
      chip_i++;
      if (chip_i == REP) begin
        fbits[bit_i] = (2 * ones > REP);
        bit_i++; chip_i = 0; ones = 0;
        flip_pos = $urandom_range(0, REP - 1);
        if (bit_i == NG) begin
          bit_i = 0; dec_frames++;
          checks++;
          if (word_q.size() == 0) begin
            failures++; $display("FAIL decode_extra: got frame %h required none", fbits);
          end else begin
            dw = word_q.pop_front();
`ifdef REP4_TX_PARITY_EN
            ebits = {1'b1, ^dw, dw, 1'b0};
`else
            ebits = {1'b1, dw, 1'b0};
`endif
            if (fbits !== ebits) begin failures++; $display("FAIL decode: got %h required %h", fbits, ebits); end
          end
        end
      end
    end else begin
      chip_i = 0; bit_i = 0; ones = 0;
      flip_pos = $urandom_range(0, REP - 1);
    end
  end

  task automatic send_a(input logic [7:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (ready_a !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n >= 200) begin failures++; $display("FAIL ready_a_timeout: got %0d clks required <200", n); end
    data_a = w; valid_a = 1'b1;
    push_frame(w, 1'b0); word_q.push_back(w);
    @(posedge clk); #1 valid_a = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (line_a !== 1'b1) begin failures++; $display("FAIL reset_line: got %b required 1", line_a); end
    checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b required 0", ready_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy_a); end
    checks++; if (strobe_a !== 1'b0) begin failures++; $display("FAIL reset_strobe: got %b required 0", strobe_a); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL post_reset_ready_a: got %b required 1", ready_a); end
    checks++; if (ready_b !== 1'b1) begin failures++; $display("FAIL post_reset_ready_b: got %b required 1", ready_b); end
  endtask

  task automatic test_frame_a5;
    int cnt, strobes;
    send_a(8'hA5);
    @(negedge clk);
    checks++; if (line_a !== 1'b0) begin failures++; $display("FAIL a5_latency_line: got %b required 0", line_a); end
    checks++; if (strobe_a !== 1'b1) begin failures++; $display("FAIL a5_first_strobe: got %b required 1", strobe_a); end
    checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL a5_ready_busy: got %b required 0", ready_a); end
    cnt = 0; strobes = 0;
    while (busy_a === 1'b1 && cnt < 200) begin
      cnt++;
      if (strobe_a === 1'b1) strobes++;
      @(negedge clk);
    end
    checks++; if (cnt != FL) begin failures++; $display("FAIL a5_busy_len: got %0d required %0d", cnt, FL); end
    checks++; if (strobes != NG) begin failures++; $display("FAIL a5_strobes: got %0d required %0d", strobes, NG); end
    checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL a5_ready_after: got %b required 1", ready_a); end
  endtask

  task automatic test_back_to_back;
    int cnt, n;
    n = 0;
    @(negedge clk);
    while (ready_a !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    data_a = 8'hA5; valid_a = 1'b1;
    push_frame(8'hA5, 1'b0); word_q.push_back(8'hA5);
    @(posedge clk); #1 data_a = 8'h3C;
    push_frame(8'h3C, 1'b0); word_q.push_back(8'h3C);
    cnt = 0;
    @(negedge clk);
    while (busy_a === 1'b1 && cnt < 200) begin cnt++; @(negedge clk); end
    checks++; if (cnt != FL) begin failures++; $display("FAIL b2b_first_len: got %0d required %0d", cnt, FL); end
    checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL b2b_idle_ready: got %b required 1", ready_a); end
    @(posedge clk); #1 valid_a = 1'b0;
    @(negedge clk);
    checks++; if (busy_a !== 1'b1 || line_a !== 1'b0) begin
      failures++; $display("FAIL b2b_second_start: got busy=%b line=%b required busy=1 line=0", busy_a, line_a);
    end
    cnt = 0;
    while (busy_a === 1'b1 && cnt < 200) begin cnt++; @(negedge clk); end
    checks++; if (cnt != FL) begin failures++; $display("FAIL b2b_second_len: got %0d required %0d", cnt, FL); end
  endtask

  task automatic test_rst_midframe;
    int cnt;
    send_a(8'h5A);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (line_a !== 1'b1) begin failures++; $display("FAIL midrst_line: got %b required 1", line_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b required 0", busy_a); end
    checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL midrst_ready: got %b required 0", ready_a); end
    rst = 1'b0;
    qa.delete(); word_q.delete();
    @(negedge clk);
    checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL midrst_ready_after: got %b required 1", ready_a); end
    send_a(8'hFF);
    cnt = 0;
    @(negedge clk);
    while (busy_a === 1'b1 && cnt < 200) begin cnt++; @(negedge clk); end
    checks++; if (cnt != FL) begin failures++; $display("FAIL midrst_ff_len: got %0d required %0d", cnt, FL); end
  endtask

  task automatic test_cpc3;
    int   cnt, strobes, last, n, exp_pos;
    logic e;
    n = 0;
    @(negedge clk);
    while (ready_b !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++; if (n >= 200) begin failures++; $display("FAIL ready_b_timeout: got %0d clks required <200", n); end
    data_b = 8'h01; valid_b = 1'b1; push_frame(8'h01, 1'b1);
    @(posedge clk); #1 valid_b = 1'b0;
    cnt = 0; strobes = 0; last = 0;
    @(negedge clk);
    while (busy_b === 1'b1 && cnt < 1000) begin
      cnt++;
      checks++;
      if (qb.size() == 0) begin
        failures++; $display("FAIL cpc3_line_extra: got chip %b required no chip", line_b);
      end else begin
        e = qb.pop_front();
        if (line_b !== e) begin failures++; $display("FAIL cpc3_line clk %0d: got %b required %b", cnt, line_b, e); end
      end
      if (strobe_b === 1'b1) begin
        exp_pos = (strobes == 0) ? 1 : last + REP * 3;
        checks++; if (cnt != exp_pos) begin failures++; $display("FAIL cpc3_strobe_pos: got %0d required %0d", cnt, exp_pos); end
        last = cnt; strobes++;
      end
      @(negedge clk);
    end
    checks++; if (cnt != FL * 3) begin failures++; $display("FAIL cpc3_len: got %0d required %0d", cnt, FL * 3); end
    checks++; if (strobes != NG) begin failures++; $display("FAIL cpc3_strobes: got %0d required %0d", strobes, NG); end
    checks++; if (qb.size() != 0) begin failures++; $display("FAIL cpc3_leftover: got %0d required 0", qb.size()); end
  endtask

  task automatic drain_a(input string tag);
    int n;
    n = 0;
    while ((qa.size() != 0 || busy_a === 1'b1) && n < 5000) begin @(negedge clk); n++; end
    checks++; if (n >= 5000) begin failures++; $display("FAIL %s_drain_timeout: got %0d left required 0", tag, qa.size()); end
  endtask

  task automatic test_loopback;
    int base;
    inj_en = 1'b0; base = dec_frames;
    for (int i = 0; i < 500; i++) send_a(8'($urandom));
    drain_a("loop_clean");
    checks++; if (dec_frames - base != 500) begin failures++; $display("FAIL loop_clean_frames: got %0d required 500", dec_frames - base); end
    inj_en = 1'b1; base = dec_frames;
    for (int i = 0; i < 500; i++) send_a(8'($urandom));
    drain_a("loop_inj");
    inj_en = 1'b0;
    checks++; if (dec_frames - base != 500) begin failures++; $display("FAIL loop_inj_frames: got %0d required 500", dec_frames - base); end
    checks++; if (word_q.size() != 0) begin failures++; $display("FAIL loop_words_left: got %0d required 0", word_q.size()); end
  endtask

`ifdef REP4_TX_PARITY_EN
  task automatic test_parity;
    int cnt;
    send_a(8'hA5);
    cnt = 0; @(negedge clk);
    while (busy_a === 1'b1 && cnt < 200) begin cnt++; @(negedge clk); end
    checks++; if (cnt != 44) begin failures++; $display("FAIL parity_a5_len: got %0d required 44", cnt); end
    send_a(8'h07);
    cnt = 0; @(negedge clk);
    while (busy_a === 1'b1 && cnt < 200) begin cnt++; @(negedge clk); end
    checks++; if (cnt != 44) begin failures++; $display("FAIL parity_07_len: got %0d required 44", cnt); end
  endtask
`endif

  initial begin
    valid_a = 1'b0; valid_b = 1'b0; data_a = 8'h00; data_b = 8'h00;
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_rst_midframe();
    test_cpc3();
`ifdef REP4_TX_PARITY_EN
    test_parity();
`endif
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
